fp_angle_to_fixed: RTL and testbench

Sequential converter that accepts an IEEE-754 single-precision angle in radians and produces the signed fixed-point angle consumed by the CORDIC rotation core. It unpacks the float and range-checks it against ±π. It folds angles beyond ±π/2 into the CORDIC convergence range and reports the resulting cosine sign flip. The block sits between the float-domain angle logic (compare/select) and the fixed-point CORDIC iteration pipeline, with valid/ready handshakes on both sides.

---
 rtl/cordic_pkg.sv | 29 ++
 rtl/fp32_unpack_shift.sv | 35 +++
 rtl/fp_angle_to_fixed.sv | 113 +++++++++++
 tb/tb_fp_angle_to_fixed.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared constants for the float-to-fixed angle front end of the CORDIC core.
// The output angle format is Q3.29 signed, and the FSM state encodings live here.
package cordic_pkg;

  localparam int unsigned FRAC_W  = 29;
  localparam int unsigned ANGLE_W = 32;
  localparam int unsigned MAG_W   = 31;
  localparam int unsigned EXP_W   = 8;
  localparam int unsigned MAN_W   = 24;

  localparam logic [ANGLE_W-1:0] PI_Q      = 32'h6487ED51;
  localparam logic [ANGLE_W-1:0] HALF_PI_Q = 32'h3243F6A8;

  // Exponent at which the mantissa lands unshifted in Q3.29 (127 - 29 + 23).
  localparam int unsigned EXP_BIAS_Q = 121;
  localparam logic [EXP_W-1:0] EXP_SPECIAL   = 8'hFF;
  localparam logic [EXP_W-1:0] EXP_SHIFT_MAX = 8'd128;

  localparam int unsigned FP_SIGN_BIT = 31;
  localparam int unsigned FP_EXP_MSB  = 30;
  localparam int unsigned FP_EXP_LSB  = 23;
  localparam int unsigned FP_FRAC_MSB = 22;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] FOLD  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

endpackage

// File: rtl/fp32_unpack_shift.sv
// Maps an fp32 exponent/mantissa pair onto a 31-bit unsigned Q3.29 magnitude.
// Flags Inf/NaN and exponents too large to be any in-range angle.
module fp32_unpack_shift
  import cordic_pkg::*;
(
  input  logic [EXP_W-1:0] exponent,
  input  logic [MAN_W-1:0] mantissa,
  output logic [MAG_W-1:0] mag_c,
  output logic             err_c
);

  logic [2:0]       lsh;
  logic [EXP_W-1:0] rsh;

  always_comb begin
    mag_c = '0;
    err_c = 1'b0;
    lsh   = 3'(exponent - EXP_W'(EXP_BIAS_Q));
    rsh   = EXP_W'(EXP_BIAS_Q) - exponent;
    if (exponent == EXP_SPECIAL) begin
      err_c = 1'b1;
    end else if (exponent == '0) begin
      mag_c = '0;
    end else if (exponent > EXP_SHIFT_MAX) begin
      err_c = 1'b1;
    end else if (exponent >= EXP_W'(EXP_BIAS_Q)) begin
      mag_c = MAG_W'(mantissa) << lsh;
    end else if (rsh >= EXP_W'(MAN_W)) begin
      mag_c = '0;
    end else begin
      mag_c = MAG_W'(mantissa >> rsh);
    end
  end

endmodule

// File: rtl/fp_angle_to_fixed.sv
// Converts an fp32 radian angle into a folded Q3.29 angle for the CORDIC core.
// Angles beyond +-pi/2 are reflected through pi and flagged so cos can be negated.
module fp_angle_to_fixed
  import cordic_pkg::*;
#(
  parameter int unsigned FRAC_W = 29
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_angle,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FRAC_W+2:0] out_angle,
  output logic              out_negate,
  output logic              out_err
);

  localparam int unsigned OUT_W = FRAC_W + 3;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic             sign_q;
  logic [EXP_W-1:0] exp_q;
  logic [MAN_W-1:0] man_q;
  logic [MAG_W-1:0] mag_q;
  logic             shift_err_q;

  logic [MAG_W-1:0] mag_c;
  logic             shift_err_c;
  logic [OUT_W-1:0] mag_ext_c;
  logic [OUT_W-1:0] folded_c;
  logic [OUT_W-1:0] angle_c;
  logic             negate_c;
  logic             err_c;

  fp32_unpack_shift u_unpack (
    .exponent (exp_q),
    .mantissa (man_q),
    .mag_c    (mag_c),
    .err_c    (shift_err_c)
  );

  assign in_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = SHIFT;
      SHIFT:   state_nxt = FOLD;
      FOLD:    state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Range check, fold through pi, apply sign; errors squash the result to zero.
  always_comb begin
    mag_ext_c = OUT_W'(mag_q);
    err_c     = shift_err_q | (mag_ext_c > OUT_W'(PI_Q));
    negate_c  = 1'b0;
    folded_c  = mag_ext_c;
    if (mag_ext_c > OUT_W'(HALF_PI_Q)) begin
      folded_c = OUT_W'(PI_Q) - mag_ext_c;
      negate_c = 1'b1;
    end
    angle_c = sign_q ? (OUT_W'(0) - folded_c) : folded_c;
    if (err_c) begin
      angle_c  = '0;
      negate_c = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sign_q      <= 1'b0;
      exp_q       <= '0;
      man_q       <= '0;
      mag_q       <= '0;
      shift_err_q <= 1'b0;
      out_valid   <= 1'b0;
      out_angle   <= '0;
      out_negate  <= 1'b0;
      out_err     <= 1'b0;
    end else begin
      if (state == IDLE && in_valid) begin
        sign_q <= in_angle[FP_SIGN_BIT];
        exp_q  <= in_angle[FP_EXP_MSB:FP_EXP_LSB];
        man_q  <= {1'b1, in_angle[FP_FRAC_MSB:0]};
      end
      if (state == SHIFT) begin
        mag_q       <= mag_c;
        shift_err_q <= shift_err_c;
      end
      if (state == FOLD) begin
        out_angle  <= angle_c;
        out_negate <= negate_c;
        out_err    <= err_c;
      end
      out_valid <= (state_nxt == DONE);
    end
  end

endmodule

// File: tb/tb_fp_angle_to_fixed.sv
// Bench for fp_angle_to_fixed: arithmetic reference model, per-cycle checker,
// and directed vectors carrying hand-computed expectations.
module tb_fp_angle_to_fixed;

  localparam logic [31:0] PI_REF   = 32'h6487ED51;
  localparam logic [31:0] HALF_REF = 32'h3243F6A8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_angle = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_angle;
  logic        out_negate;
  logic        out_err;

  always #5 clk = ~clk;

  fp_angle_to_fixed #(.FRAC_W(29)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_angle   (in_angle),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_angle  (out_angle),
    .out_negate (out_negate),
    .out_err    (out_err)
  );

  typedef struct {
    logic [31:0] angle;
    logic        neg;
    logic        err;
    logic        has_lit;
    logic [31:0] l_angle;
    logic        l_neg;
    logic        l_err;
    int          acc;
  } exp_t;

  exp_t        q[$];
  int          edge_cnt = 0;
  bit          armed = 1'b0;
  bit          done = 1'b0;
  int          timeouts = 0;
  int          timeouts_seen = 0;
  int          errors = 0;
  int          checks = 0;
  logic        lit_en = 1'b0;
  logic [31:0] lit_angle = '0;
  logic        lit_neg = 1'b0;
  logic        lit_err = 1'b0;

  // Value of the angle in Q3.29 is m * 2^(e-150) * 2^29 = m * 2^(e-121).
  function automatic logic [33:0] model(input logic [31:0] a);
    int          e;
    longint      m;
    longint      mag;
    logic        err;
    logic        neg;
    logic [31:0] ang;
    e   = int'(a[30:23]);
    m   = longint'({1'b1, a[22:0]});
    mag = 0;
    err = 1'b0;
    neg = 1'b0;
    if (e == 255) err = 1'b1;
    else if (e == 0) mag = 0;
    else if (e - 121 > 16) err = 1'b1;
    else if (e >= 121) mag = m << (e - 121);
    else if (121 - e >= 40) mag = 0;
    else mag = m >> (121 - e);
    if (mag > longint'(PI_REF)) err = 1'b1;
    if (!err && mag > longint'(HALF_REF)) begin
      mag = longint'(PI_REF) - mag;
      neg = 1'b1;
    end
    ang = 32'(mag);
    if (a[31]) ang = 32'(0) - ang;
    if (err) begin
      ang = '0;
      neg = 1'b0;
    end
    return {err, neg, ang};
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h (edge %0d)", name, act, req, edge_cnt);
    end
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      edge_cnt++;
      if (rst) armed = 1'b1;
    end
  end

  // Per-cycle checker against the model queue; also owns the summary.
  initial begin
    bit          exp_v;
    bit          prev_rst;
    bit          head_seen;
    logic [33:0] m;
    logic [31:0] hold_angle;
    exp_t        ent;
    prev_rst  = 1'b0;
    head_seen = 1'b0;
    hold_angle = '0;
    forever begin
      @(negedge clk);
      exp_v = (q.size() > 0) && (edge_cnt >= q[0].acc + 2);
      if (armed) begin
        chk("out_valid", 32'(out_valid), 32'(exp_v));
        chk("in_ready", 32'(in_ready), 32'(q.size() == 0));
        if (prev_rst) begin
          chk("reset_angle", out_angle, 32'h0);
          chk("reset_negate", 32'(out_negate), 32'h0);
          chk("reset_err", 32'(out_err), 32'h0);
        end
        if (exp_v) begin
          chk("model_angle", out_angle, q[0].angle);
          chk("model_negate", 32'(out_negate), 32'(q[0].neg));
          chk("model_err", 32'(out_err), 32'(q[0].err));
          if (head_seen) begin
            chk("hold_stable", out_angle, hold_angle);
          end else if (q[0].has_lit) begin
            chk("lit_angle", out_angle, q[0].l_angle);
            chk("lit_negate", 32'(out_negate), 32'(q[0].l_neg));
            chk("lit_err", 32'(out_err), 32'(q[0].l_err));
          end
          head_seen  = 1'b1;
          hold_angle = out_angle;
        end
        if (timeouts != timeouts_seen) begin
          chk("wait_timeout", 32'(timeouts), 32'(timeouts_seen));
          timeouts_seen = timeouts;
        end
      end
      prev_rst = rst;
      if (rst) begin
        q.delete();
        head_seen = 1'b0;
      end else begin
        if (exp_v && out_valid && out_ready) begin
          void'(q.pop_front());
          head_seen = 1'b0;
        end
        if (in_valid && in_ready) begin
          m           = model(in_angle);
          ent.angle   = m[31:0];
          ent.neg     = m[32];
          ent.err     = m[33];
          ent.has_lit = lit_en;
          ent.l_angle = lit_angle;
          ent.l_neg   = lit_neg;
          ent.l_err   = lit_err;
          ent.acc     = edge_cnt + 1;
          q.push_back(ent);
        end
      end
      if (done) begin
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
      end
    end
  end

  task automatic set_lit(input logic [31:0] a, input logic n, input logic e);
    lit_en    = 1'b1;
    lit_angle = a;
    lit_neg   = n;
    lit_err   = e;
  endtask

  task automatic wait_acc();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 20);
    if (!in_ready) timeouts++;
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 20);
    if (!out_valid) timeouts++;
  endtask

  // Returns just after the accept edge, with in_valid already dropped.
  task automatic send(input logic [31:0] a);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_angle = a;
    wait_acc();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] ea, input logic en, input logic ee);
    set_lit(ea, en, ee);
    send(a);
    wait_out();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    run(32'h00000000, 32'h00000000, 1'b0, 1'b0);
    run(32'h80000000, 32'h00000000, 1'b0, 1'b0);
    run(32'h00000001, 32'h00000000, 1'b0, 1'b0);
    run(32'h3F800000, 32'h20000000, 1'b0, 1'b0);
    run(32'h3F000000, 32'h10000000, 1'b0, 1'b0);
    run(32'hBF800000, 32'hE0000000, 1'b0, 1'b0);
    run(32'h30000000, 32'h00000000, 1'b0, 1'b0);
    run(32'h3FC00000, 32'h30000000, 1'b0, 1'b0);
    run(32'hC0000000, 32'hDB7812AF, 1'b1, 1'b0);
    run(32'h40000000, 32'h2487ED51, 1'b1, 1'b0);
    run(32'h7F800000, 32'h00000000, 1'b0, 1'b1);
    run(32'h7FC00000, 32'h00000000, 1'b0, 1'b1);
    run(32'h40800000, 32'h00000000, 1'b0, 1'b1);
    run(32'h40490FDC, 32'h00000000, 1'b0, 1'b1);

    // Backpressure: result must hold for five stalled cycles.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    run(32'h3FC00000, 32'h30000000, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1;
    out_ready = 1'b1;

    // Back-to-back with in_valid held high across both accepts.
    set_lit(32'h20000000, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_angle = 32'h3F800000;
    wait_acc();
    @(posedge clk);
    #1;
    in_angle = 32'hC0000000;
    set_lit(32'hDB7812AF, 1'b1, 1'b0);
    wait_acc();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_out();

    // Reset while in SHIFT.
    set_lit(32'h20000000, 1'b0, 1'b0);
    send(32'h3F800000);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    run(32'h3F800000, 32'h20000000, 1'b0, 1'b0);

    // Reset while stalled in DONE.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    run(32'h40000000, 32'h2487ED51, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    run(32'h3F800000, 32'h20000000, 1'b0, 1'b0);

    repeat (4) @(posedge clk);
    done = 1'b1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
